// File: rtl/sprite_ram_writer_if.sv
// Byte-stream input and sprite-RAM write port of the sprite loader.
// The master drives the byte stream and control; the slave is the loader itself.
interface sprite_ram_writer_if #(
    parameter int unsigned ADDR_W = 19
);
    logic              start;
    logic              abort;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_data;
    logic              busy;
    logic              done;

    modport master (
        output start,
        output abort,
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  abort,
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output wr_en,
        output wr_addr,
        output wr_data,
        output busy,
        output done
    );
endinterface

// File: rtl/sprite_ram_writer.sv
// Packs an R,G,B byte stream into 24-bit pixels and writes them row-major
// into the sprite frame RAM, starting at address 0 for every load.
module sprite_ram_writer #(
    parameter int unsigned WIDTH  = 50,
    parameter int unsigned HEIGHT = 50,
    parameter int unsigned ADDR_W = 19
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    sprite_ram_writer_if.slave   bus
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(WIDTH * HEIGHT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StGetR,
        StGetG,
        StGetB,
        StWrite
    } state_e;

    state_e            state_q;
    logic [7:0]        r_q;
    logic [7:0]        g_q;
    logic [7:0]        b_q;
    logic [ADDR_W-1:0] addr_q;
    logic              done_q;

    logic collecting;
    logic byte_ready;
    logic handshake;
    logic abort_now;

    assign collecting = (state_q == StGetR) || (state_q == StGetG) || (state_q == StGetB);
    assign byte_ready = collecting && !bus.abort;
    assign handshake  = bus.byte_valid && byte_ready;
    assign abort_now  = bus.abort && (state_q != StIdle);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            r_q     <= 8'h00;
            g_q     <= 8'h00;
            b_q     <= 8'h00;
            addr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_now) begin
                // Drop any partial pixel; the next load restarts cleanly at 0.
                state_q <= StIdle;
                r_q     <= 8'h00;
                g_q     <= 8'h00;
                b_q     <= 8'h00;
                addr_q  <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        addr_q <= '0;
                        if (bus.start) begin
                            state_q <= StGetR;
                        end
                    end
                    StGetR: begin
                        if (handshake) begin
                            r_q     <= bus.byte_in;
                            state_q <= StGetG;
                        end
                    end
                    StGetG: begin
                        if (handshake) begin
                            g_q     <= bus.byte_in;
                            state_q <= StGetB;
                        end
                    end
                    StGetB: begin
                        if (handshake) begin
                            b_q     <= bus.byte_in;
                            state_q <= StWrite;
                        end
                    end
                    StWrite: begin
                        if (addr_q == LastAddr) begin
                            state_q <= StIdle;
                            addr_q  <= '0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StGetR;
                            addr_q  <= addr_q + ADDR_W'(1);
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    // Abort must suppress the write strobe in the very cycle it arrives.
    assign bus.wr_en      = (state_q == StWrite) && !bus.abort;
    assign bus.wr_addr    = addr_q;
    assign bus.wr_data    = {r_q, g_q, b_q};
    assign bus.busy       = (state_q != StIdle);
    assign bus.done       = done_q;
    assign bus.byte_ready = byte_ready;

endmodule

// File: tb/tb_sprite_ram_writer.sv
// Directed bench for sprite_ram_writer: reset, single pixel, full loads,
// aborts, start-while-busy and asynchronous reset mid-load.
module tb_sprite_ram_writer;

    localparam int unsigned AW = 19;

    logic Clk;
    logic Reset_n;

    sprite_ram_writer_if #(.ADDR_W(AW)) bus ();

    sprite_ram_writer #(
        .WIDTH  (50),
        .HEIGHT (50),
        .ADDR_W (AW)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [AW-1:0] log_addr[$];
    logic [23:0]   log_data[$];
    int            done_cnt;
    int            done_busy_bad;
    int            t_last;
    int            t_done;

    always @(posedge Clk) cyc++;

    always @(negedge Clk) begin
        if (bus.wr_en) begin
            log_addr.push_back(bus.wr_addr);
            log_data.push_back(bus.wr_data);
            if (bus.wr_addr == AW'(2499)) t_last = cyc;
        end
        if (bus.done) begin
            done_cnt++;
            t_done = cyc;
            if (bus.busy) done_busy_bad++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [23:0] pix(input int i, input int seed);
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        r = 8'(i);
        g = 8'((i >> 8) ^ seed);
        b = 8'(i * 3 + seed);
        return {r, g, b};
    endfunction

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        done_cnt      = 0;
        done_busy_bad = 0;
        t_last        = -1;
        t_done        = -1;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic pulse_abort();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
    endtask

    // Junk on byte_in during gaps catches capture while byte_valid is low.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        for (int i = 0; i < gap; i++) begin
            bus.byte_valid = 1'b0;
            bus.byte_in    = 8'($urandom);
            step();
        end
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 32 && !ok; i++) begin
            @(negedge Clk);
            if (bus.byte_ready) ok = 1'b1;
            step();
        end
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'($urandom);
        if (!ok) check("handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_pixel(input logic [23:0] p, input int gap_max);
        send_byte(p[23:16], (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0);
        send_byte(p[15:8],  (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0);
        send_byte(p[7:0],   (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0);
    endtask

    task automatic full_load(input int gap_max, input int seed, input string tag);
        int t0;
        int bad;
        clear_log();
        pulse_start();
        t0 = cyc;
        for (int i = 0; i < 2500; i++) send_pixel(pix(i, seed), gap_max);
        repeat (4) step();
        bad = 0;
        foreach (log_addr[k]) begin
            if (log_addr[k] !== AW'(k) || log_data[k] !== pix(k, seed)) bad++;
        end
        check({tag, "_writes"}, 32'(log_addr.size()), 32'd2500);
        check({tag, "_bad_writes"}, 32'(bad), 32'd0);
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, "_done_after_last"}, 32'(t_done - t_last), 32'd1);
        check({tag, "_busy_with_done"}, 32'(done_busy_bad), 32'd0);
        check({tag, "_idle_after"}, 32'(bus.busy), 32'd0);
        if (gap_max == 0) check({tag, "_span"}, 32'(t_last - t0 + 1), 32'd10000);
    endtask

    initial begin
        int seen;
        Reset_n        = 1'b0;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        clear_log();
        repeat (3) @(posedge Clk);
        #1;
        Reset_n = 1'b1;

        // Reset state, and byte_ready must stay low in IDLE even with valid data.
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ready", 32'(bus.byte_ready), 32'd0);
        check("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        check("rst_wr_data", 32'(bus.wr_data), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        bus.byte_valid = 1'b1;
        bus.byte_in    = 8'hAA;
        seen = 0;
        repeat (5) begin
            @(negedge Clk);
            if (bus.byte_ready) seen++;
        end
        step();
        bus.byte_valid = 1'b0;
        check("idle_ready_low", 32'(seen), 32'd0);
        check("idle_no_write", 32'(log_addr.size()), 32'd0);

        // Single pixel 0x12,0x34,0x56.
        clear_log();
        pulse_start();
        check("start_busy", 32'(bus.busy), 32'd1);
        check("start_ready", 32'(bus.byte_ready), 32'd1);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'h56, 0);
        check("px_wr_en", 32'(bus.wr_en), 32'd1);
        check("px_wr_addr", 32'(bus.wr_addr), 32'd0);
        check("px_wr_data", 32'(bus.wr_data), 32'h123456);
        check("px_ready_in_write", 32'(bus.byte_ready), 32'd0);
        step();
        check("px_wr_en_after", 32'(bus.wr_en), 32'd0);
        check("px_ready_after", 32'(bus.byte_ready), 32'd1);
        check("px_next_addr", 32'(bus.wr_addr), 32'd1);
        pulse_abort();
        check("px_abort_idle", 32'(bus.busy), 32'd0);
        check("px_no_done", 32'(done_cnt), 32'd0);

        full_load(0, 8'h5A, "full");
        full_load(3, 8'hC3, "gappy");

        // Abort after two pixels plus the R byte of the third.
        clear_log();
        pulse_start();
        send_pixel(24'hA1B2C3, 0);
        send_pixel(24'hD4E5F6, 0);
        send_byte(8'h77, 0);
        bus.abort = 1'b1;
        #1;
        check("abort_ready_low", 32'(bus.byte_ready), 32'd0);
        step();
        bus.abort = 1'b0;
        check("abort_idle", 32'(bus.busy), 32'd0);
        repeat (3) step();
        check("abort_writes", 32'(log_addr.size()), 32'd2);
        check("abort_no_done", 32'(done_cnt), 32'd0);
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        check("restart_addr", 32'(bus.wr_addr), 32'd0);
        check("restart_data", 32'(bus.wr_data), 32'h010203);
        check("restart_wr_en", 32'(bus.wr_en), 32'd1);
        pulse_abort();

        // Abort landing in the WRITE cycle.
        clear_log();
        pulse_start();
        send_pixel(24'h665544, 0);
        bus.abort = 1'b1;
        #1;
        check("abortw_wr_en", 32'(bus.wr_en), 32'd0);
        check("abortw_ready", 32'(bus.byte_ready), 32'd0);
        step();
        bus.abort = 1'b0;
        check("abortw_idle", 32'(bus.busy), 32'd0);
        repeat (2) step();
        check("abortw_no_write", 32'(log_addr.size()), 32'd0);
        check("abortw_no_done", 32'(done_cnt), 32'd0);

        // start while busy must not disturb the address sequence.
        clear_log();
        pulse_start();
        for (int i = 0; i < 10; i++) send_pixel(pix(i, 1), 0);
        step();
        pulse_start();
        for (int i = 10; i < 13; i++) send_pixel(pix(i, 1), 0);
        step();
        check("sbusy_writes", 32'(log_addr.size()), 32'd13);
        if (log_addr.size() == 13) begin
            check("sbusy_addr10", 32'(log_addr[10]), 32'd10);
            check("sbusy_addr12", 32'(log_addr[12]), 32'd12);
            check("sbusy_data11", 32'(log_data[11]), 32'(pix(11, 1)));
        end
        pulse_abort();

        // Asynchronous reset during a WRITE cycle.
        clear_log();
        pulse_start();
        send_pixel(24'h112233, 0);
        send_pixel(24'h445566, 0);
        check("rml_pre_wr_en", 32'(bus.wr_en), 32'd1);
        #2;
        Reset_n = 1'b0;
        #1;
        check("rml_wr_en", 32'(bus.wr_en), 32'd0);
        check("rml_wr_addr", 32'(bus.wr_addr), 32'd0);
        check("rml_wr_data", 32'(bus.wr_data), 32'd0);
        check("rml_busy", 32'(bus.busy), 32'd0);
        check("rml_ready", 32'(bus.byte_ready), 32'd0);
        check("rml_done", 32'(bus.done), 32'd0);
        bus.byte_valid = 1'b1;
        repeat (3) step();
        bus.byte_valid = 1'b0;
        Reset_n = 1'b1;
        repeat (2) step();
        check("rml_writes", 32'(log_addr.size()), 32'd1);
        check("rml_idle", 32'(bus.busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
